// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for raw board switches.
// Optional change strobes are built only when SW_DEBOUNCE_CHANGE_PULSE_EN is defined.
module sw_debounce #(
   parameter int NB_SW         = 4,
   parameter int NB_COUNTER    = 20,
   parameter int STABLE_CYCLES = 1000000
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [NB_SW-1:0] i_sw,
   output logic [NB_SW-1:0] o_sw,
   output logic [NB_SW-1:0] o_sw_changed,
   output logic             o_any_changed
);

   localparam logic [NB_COUNTER-1:0] CNT_MAX = NB_COUNTER'(STABLE_CYCLES - 1);

   logic [NB_SW-1:0]      s1_q, s1_d;
   logic [NB_SW-1:0]      s2_q, s2_d;
   logic [NB_SW-1:0]      sw_q, sw_d;
   logic [NB_COUNTER-1:0] cnt_q [NB_SW];
   logic [NB_COUNTER-1:0] cnt_d [NB_SW];
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
   logic [NB_SW-1:0]      chg_q, chg_d;
   logic                  any_q, any_d;
`endif

   always_comb begin
      s1_d = i_sw;
      s2_d = s1_q;
      sw_d = sw_q;
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      chg_d = '0;
`endif
      for (int i = 0; i < NB_SW; i++) begin
         cnt_d[i] = cnt_q[i];
         // Any return to the accepted level discards the partial count.
         if (s2_q[i] == sw_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            sw_d[i]  = s2_q[i];
            cnt_d[i] = '0;
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
            chg_d[i] = 1'b1;
`endif
         end else begin
            cnt_d[i] = cnt_q[i] + NB_COUNTER'(1);
         end
      end
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
      any_d = |chg_d;
`endif
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         s1_q <= '0;
         s2_q <= '0;
         sw_q <= '0;
         for (int i = 0; i < NB_SW; i++) cnt_q[i] <= '0;
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
         chg_q <= '0;
         any_q <= 1'b0;
`endif
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         sw_q <= sw_d;
         for (int i = 0; i < NB_SW; i++) cnt_q[i] <= cnt_d[i];
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
         chg_q <= chg_d;
         any_q <= any_d;
`endif
      end
   end

   assign o_sw = sw_q;
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
   assign o_sw_changed  = chg_q;
   assign o_any_changed = any_q;
`else
   assign o_sw_changed  = '0;
   assign o_any_changed = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=8; strobe expectations follow the build macro.
module tb_sw_debounce;
   localparam int NB_SW         = 4;
   localparam int NB_COUNTER    = 4;
   localparam int STABLE_CYCLES = 8;
`ifdef SW_DEBOUNCE_CHANGE_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             i_reset;
   logic [NB_SW-1:0] i_sw;
   logic [NB_SW-1:0] o_sw;
   logic [NB_SW-1:0] o_sw_changed;
   logic             o_any_changed;

   int total = 0;
   int bad   = 0;

   sw_debounce #(
      .NB_SW(NB_SW), .NB_COUNTER(NB_COUNTER), .STABLE_CYCLES(STABLE_CYCLES)
   ) dut (
      .clock(clock), .i_reset(i_reset), .i_sw(i_sw),
      .o_sw(o_sw), .o_sw_changed(o_sw_changed), .o_any_changed(o_any_changed)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // All switches high through reset: accepted together 10 edges after release.
   task automatic test_reset();
      logic [3:0] ew, ec;
      i_reset = 1'b1;
      i_sw    = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (o_sw !== 4'b0000) begin bad++; $display("FAIL reset_o_sw: got %b want 0000", o_sw); end
         total++;
         if (o_sw_changed !== 4'b0000 || o_any_changed !== 1'b0) begin
            bad++; $display("FAIL reset_strobe: got %b/%b want 0000/0", o_sw_changed, o_any_changed);
         end
      end
      i_reset = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         ew = (k >= 10) ? 4'b1111 : 4'b0000;
         ec = (k == 10 && PULSE_EN) ? 4'b1111 : 4'b0000;
         total++;
         if (o_sw !== ew) begin bad++; $display("FAIL release_o_sw edge %0d: got %b want %b", k, o_sw, ew); end
         total++;
         if (o_sw_changed !== ec) begin bad++; $display("FAIL release_chg edge %0d: got %b want %b", k, o_sw_changed, ec); end
         total++;
         if (o_any_changed !== (ec != 4'b0000)) begin
            bad++; $display("FAIL release_any edge %0d: got %b want %b", k, o_any_changed, (ec != 4'b0000));
         end
      end
   endtask

   // Single bit 0->1 held stable from a clean all-zero state.
   task automatic test_change();
      logic [3:0] ew, ec;
      i_sw    = 4'b0000;
      i_reset = 1'b1;
      tick(); tick();
      i_reset = 1'b0;
      repeat (3) tick();
      i_sw[0] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         ew = (k >= 10) ? 4'b0001 : 4'b0000;
         ec = (k == 10 && PULSE_EN) ? 4'b0001 : 4'b0000;
         total++;
         if (o_sw !== ew) begin bad++; $display("FAIL change_o_sw edge %0d: got %b want %b", k, o_sw, ew); end
         total++;
         if (o_sw_changed !== ec) begin bad++; $display("FAIL change_chg edge %0d: got %b want %b", k, o_sw_changed, ec); end
         total++;
         if (o_any_changed !== (ec != 4'b0000)) begin
            bad++; $display("FAIL change_any edge %0d: got %b want %b", k, o_any_changed, (ec != 4'b0000));
         end
      end
   endtask

   // Bit 3 bounces every 3 cycles, then holds high.
   task automatic test_bounce();
      logic [3:0] ew, ec;
      for (int b = 0; b < 4; b++) begin
         i_sw[3] = (b % 2 == 0) ? 1'b1 : 1'b0;
         for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_sw !== 4'b0001 || o_sw_changed !== 4'b0000 || o_any_changed !== 1'b0) begin
               bad++; $display("FAIL bounce_hold: got %b/%b/%b want 0001/0000/0", o_sw, o_sw_changed, o_any_changed);
            end
         end
      end
      i_sw[3] = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         ew = (k >= 10) ? 4'b1001 : 4'b0001;
         ec = (k == 10 && PULSE_EN) ? 4'b1000 : 4'b0000;
         total++;
         if (o_sw !== ew) begin bad++; $display("FAIL bounce_o_sw edge %0d: got %b want %b", k, o_sw, ew); end
         total++;
         if (o_sw_changed !== ec || o_any_changed !== (ec != 4'b0000)) begin
            bad++; $display("FAIL bounce_chg edge %0d: got %b/%b want %b", k, o_sw_changed, o_any_changed, ec);
         end
      end
   endtask

   // Short pulse on bit 1 filtered; longer pulse accepted on both edges.
   task automatic test_pulse_width();
      logic [3:0] ew, ec;
      i_sw[1] = 1'b1;
      repeat (STABLE_CYCLES - 1) tick();
      i_sw[1] = 1'b0;
      for (int k = 0; k < 14; k++) begin
         tick();
         total++;
         if (o_sw !== 4'b1001 || o_sw_changed !== 4'b0000) begin
            bad++; $display("FAIL short_pulse: got %b/%b want 1001/0000", o_sw, o_sw_changed);
         end
      end
      i_sw[1] = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         total++;
         if (o_sw !== 4'b1001 || o_sw_changed !== 4'b0000) begin
            bad++; $display("FAIL long_pulse_wait edge %0d: got %b/%b want 1001/0000", k, o_sw, o_sw_changed);
         end
      end
      i_sw[1] = 1'b0;
      // Fall-edge numbering: edge 1 here is also the rise acceptance edge.
      for (int k = 1; k <= 11; k++) begin
         tick();
         ew = (k >= 10) ? 4'b1001 : 4'b1011;
         ec = ((k == 1 || k == 10) && PULSE_EN) ? 4'b0010 : 4'b0000;
         total++;
         if (o_sw !== ew) begin bad++; $display("FAIL long_pulse_o_sw edge %0d: got %b want %b", k, o_sw, ew); end
         total++;
         if (o_sw_changed !== ec || o_any_changed !== (ec != 4'b0000)) begin
            bad++; $display("FAIL long_pulse_chg edge %0d: got %b/%b want %b", k, o_sw_changed, o_any_changed, ec);
         end
      end
   endtask

   // Reset lands while bit 2 has cnt=5; everything restarts on release.
   task automatic test_reset_mid();
      logic [3:0] ew, ec;
      i_sw[2] = 1'b1;
      repeat (7) tick();
      total++;
      if (dut.cnt_q[2] !== 4'd5) begin bad++; $display("FAIL mid_cnt_before: got %0d want 5", dut.cnt_q[2]); end
      i_reset = 1'b1;
      tick();
      total++;
      if (o_sw !== 4'b0000 || o_sw_changed !== 4'b0000 || o_any_changed !== 1'b0) begin
         bad++; $display("FAIL mid_reset_out: got %b/%b/%b want 0000/0000/0", o_sw, o_sw_changed, o_any_changed);
      end
      total++;
      if (dut.cnt_q[2] !== 4'd0) begin bad++; $display("FAIL mid_reset_cnt: got %0d want 0", dut.cnt_q[2]); end
      i_reset = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         ew = (k >= 10) ? 4'b1101 : 4'b0000;
         ec = (k == 10 && PULSE_EN) ? 4'b1101 : 4'b0000;
         total++;
         if (o_sw !== ew) begin bad++; $display("FAIL mid_o_sw edge %0d: got %b want %b", k, o_sw, ew); end
         total++;
         if (o_sw_changed !== ec || o_any_changed !== (ec != 4'b0000)) begin
            bad++; $display("FAIL mid_chg edge %0d: got %b/%b want %b", k, o_sw_changed, o_any_changed, ec);
         end
      end
   endtask

   initial begin
      i_reset = 1'b1;
      i_sw    = 4'b0000;
      test_reset();
      test_change();
      test_bounce();
      test_pulse_width();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
